// File: rtl/step_clock_control.sv
// Clock-enable generator for the CPU core: manual step, divided free-run
// and N-step bursts, with breakpoint halt and a wrapping step counter.
module step_clock_control #(
    parameter int DIV_WIDTH   = 24,
    parameter int BURST_WIDTH = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   sysclk,
    input  logic                   rst,
    input  logic [DIV_WIDTH-1:0]   div,
    input  logic [BURST_WIDTH-1:0] burst_len,
    input  logic                   manual_button_pulse,
    input  logic                   automatic_button_pulse,
    input  logic                   burst_button_pulse,
    input  logic                   halt_request,
    output logic                   clk_en,
    output logic [1:0]             mode,
    output logic [BURST_WIDTH-1:0] burst_remaining,
    output logic [CNT_WIDTH-1:0]   step_count
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        AUTO   = 2'd1,
        BURST  = 2'd2
    } mode_e;

    typedef enum logic [2:0] {
        ACT_IDLE,
        ACT_STEP,
        ACT_TICK,
        ACT_STOP,
        ACT_AUTO,
        ACT_BURST
    } act_e;

    mode_e                  state_q;
    mode_e                  state_d;
    act_e                   act;
    act_e                   burst_act;
    logic [DIV_WIDTH-1:0]   div_cnt_q;
    logic [DIV_WIDTH-1:0]   div_cnt_d;
    logic [BURST_WIDTH-1:0] rem_q;
    logic [BURST_WIDTH-1:0] rem_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic                   clk_en_q;
    logic                   clk_en_d;
    logic                   tick;

    // >= so that lowering div mid-run fires at once instead of wrapping
    assign tick      = (state_q != MANUAL) && (div_cnt_q >= div);
    assign burst_act = (burst_len == '0) ? ACT_STOP : ACT_BURST;

    always_comb begin
        act = ACT_IDLE;
        unique case (state_q)
            MANUAL: begin
                if (manual_button_pulse)         act = ACT_STEP;
                else if (burst_button_pulse)     act = burst_act;
                else if (automatic_button_pulse) act = ACT_AUTO;
            end
            AUTO: begin
                if (halt_request || manual_button_pulse) act = ACT_STOP;
                else if (burst_button_pulse)             act = burst_act;
                else if (tick)                           act = ACT_TICK;
            end
            BURST: begin
                if (halt_request || manual_button_pulse) act = ACT_STOP;
                else if (burst_button_pulse)             act = burst_act;
                else if (automatic_button_pulse)         act = ACT_AUTO;
                else if (tick)                           act = ACT_TICK;
            end
            default: act = ACT_STOP;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q   <= MANUAL;
            div_cnt_q <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            clk_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            clk_en_q  <= clk_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (act)
            ACT_STOP:  state_d = MANUAL;
            ACT_AUTO:  state_d = AUTO;
            ACT_BURST: state_d = BURST;
            ACT_TICK: begin
                // last burst tick drops to MANUAL on the same edge
                if (state_q == BURST && rem_q == BURST_WIDTH'(1))
                    state_d = MANUAL;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        clk_en_d  = (act == ACT_STEP) || (act == ACT_TICK);
        rem_d     = rem_q;
        div_cnt_d = '0;
        cnt_d     = cnt_q + {{(CNT_WIDTH-1){1'b0}}, clk_en_d};
        unique case (act)
            ACT_STOP:  rem_d = '0;
            ACT_AUTO:  rem_d = '0;
            ACT_BURST: rem_d = burst_len;
            ACT_TICK: begin
                if (state_q == BURST)
                    rem_d = rem_q - BURST_WIDTH'(1);
            end
            ACT_IDLE: begin
                if (state_q != MANUAL)
                    div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
            end
            default: rem_d = rem_q;
        endcase
    end

    assign clk_en          = clk_en_q;
    assign mode            = state_q;
    assign burst_remaining = rem_q;
    assign step_count      = cnt_q;

endmodule

// File: tb/tb_step_clock_control.sv
// Bench for step_clock_control: vector table plus multi-cycle sequences,
// expected outputs queued per driven cycle and checked after each edge.
module tb_step_clock_control;

    localparam int DW = 24;
    localparam int BW = 8;
    localparam int CW = 4;

    typedef struct {
        logic          rst;
        logic          man;
        logic          aut;
        logic          bur;
        logic          halt;
        logic [DW-1:0] div;
        logic [BW-1:0] blen;
        logic          en;
        logic [1:0]    mode;
        logic [BW-1:0] rem;
    } vec_t;

    typedef struct {
        logic          en;
        logic [1:0]    mode;
        logic [BW-1:0] rem;
        logic [CW-1:0] cnt;
        int            id;
    } exp_t;

    logic          sysclk = 1'b0;
    logic          rst;
    logic [DW-1:0] div;
    logic [BW-1:0] burst_len;
    logic          manual_button_pulse;
    logic          automatic_button_pulse;
    logic          burst_button_pulse;
    logic          halt_request;
    logic          clk_en;
    logic [1:0]    mode;
    logic [BW-1:0] burst_remaining;
    logic [CW-1:0] step_count;

    exp_t          sb[$];
    exp_t          ce;
    vec_t          tbl[$];
    int            checks   = 0;
    int            failures = 0;
    int            vec_id   = 0;
    logic [CW-1:0] exp_cnt  = '0;
    logic [DW-1:0] cur_div  = '0;
    logic [BW-1:0] cur_blen = '0;

    always #5 sysclk = ~sysclk;

    step_clock_control #(
        .DIV_WIDTH  (DW),
        .BURST_WIDTH(BW),
        .CNT_WIDTH  (CW)
    ) dut (
        .sysclk                (sysclk),
        .rst                   (rst),
        .div                   (div),
        .burst_len             (burst_len),
        .manual_button_pulse   (manual_button_pulse),
        .automatic_button_pulse(automatic_button_pulse),
        .burst_button_pulse    (burst_button_pulse),
        .halt_request          (halt_request),
        .clk_en                (clk_en),
        .mode                  (mode),
        .burst_remaining       (burst_remaining),
        .step_count            (step_count)
    );

    task automatic chk(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", nm, id, act, exp);
        end
    endtask

    always @(posedge sysclk) begin
        #1;
        if (sb.size() > 0) begin
            ce = sb.pop_front();
            chk("clk_en", ce.id, 32'(clk_en), 32'(ce.en));
            chk("mode", ce.id, 32'(mode), 32'(ce.mode));
            chk("burst_remaining", ce.id, 32'(burst_remaining), 32'(ce.rem));
            chk("step_count", ce.id, 32'(step_count), 32'(ce.cnt));
        end
    end

    function automatic vec_t mk(input logic r, input logic m,
                                input logic a, input logic b,
                                input logic h, input logic [DW-1:0] d,
                                input logic [BW-1:0] bl, input logic e,
                                input logic [1:0] md, input logic [BW-1:0] rm);
        vec_t v;
        v.rst = r; v.man = m; v.aut = a; v.bur = b; v.halt = h;
        v.div = d; v.blen = bl; v.en = e; v.mode = md; v.rem = rm;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        exp_t x;
        @(negedge sysclk);
        rst                    = v.rst;
        manual_button_pulse    = v.man;
        automatic_button_pulse = v.aut;
        burst_button_pulse     = v.bur;
        halt_request           = v.halt;
        div                    = v.div;
        burst_len              = v.blen;
        exp_cnt = v.rst ? '0 : exp_cnt + CW'(v.en);
        x.en   = v.en;
        x.mode = v.mode;
        x.rem  = v.rem;
        x.cnt  = exp_cnt;
        x.id   = vec_id;
        sb.push_back(x);
        vec_id++;
        @(posedge sysclk);
    endtask

    task automatic cyc(input logic r, input logic m, input logic a,
                       input logic b, input logic h, input logic e,
                       input logic [1:0] md, input logic [BW-1:0] rm);
        apply(mk(r, m, a, b, h, cur_div, cur_blen, e, md, rm));
    endtask

    initial begin
        rst = 1'b1;
        manual_button_pulse = 1'b0;
        automatic_button_pulse = 1'b0;
        burst_button_pulse = 1'b0;
        halt_request = 1'b0;
        div = '0;
        burst_len = '0;

        // reset, three spaced manual steps, and single-cycle corner cases
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int p = 0; p < 3; p++) begin
            tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
            for (int q = 0; q < 4; q++)
                tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        tbl.push_back(mk(0, 0, 0, 1, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 4, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 3, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 4, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 1, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 4, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i]);

        // AUTO at div=4; manual press on a tick edge suppresses it
        cur_div = 4;
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        for (int j = 1; j <= 54; j++)
            cyc(0, 0, (j == 20), 0, 0, (j % 5 == 0), 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // burst of 6 at div=2
        cur_div = 2; cur_blen = 6;
        cyc(0, 0, 0, 1, 0, 0, 2, 6);
        for (int j = 1; j <= 18; j++)
            cyc(0, 0, 0, 0, 0, (j % 3 == 0), (j == 18) ? 2'd0 : 2'd2,
                BW'(6 - j / 3));
        for (int j = 0; j < 3; j++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // halt the cycle after the 4th pulse, div=0
        cur_div = 0; cur_blen = 10;
        cyc(0, 0, 0, 1, 0, 0, 2, 10);
        for (int j = 1; j <= 4; j++)
            cyc(0, 0, 0, 0, 0, 1, 2, BW'(10 - j));
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // halt coinciding with a tick, div=2
        cur_div = 2;
        cyc(0, 0, 0, 1, 0, 0, 2, 10);
        for (int j = 1; j <= 5; j++)
            cyc(0, 0, 0, 0, 0, (j == 3), 2, (j >= 3) ? 8'd9 : 8'd10);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0, 0);

        // automatic press mid-burst restarts the divider in AUTO
        cur_blen = 6;
        cyc(0, 0, 0, 1, 0, 0, 2, 6);
        for (int j = 1; j <= 3; j++)
            cyc(0, 0, 0, 0, 0, (j == 3), 2, (j == 3) ? 8'd5 : 8'd6);
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);

        // div lowered from 100 to 3 with the divider at 50
        cur_div = 100;
        cyc(0, 0, 1, 0, 0, 0, 1, 0);
        for (int j = 1; j <= 50; j++)
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
        cur_div = 3;
        for (int j = 51; j <= 59; j++)
            cyc(0, 0, 0, 0, 0, ((j - 51) % 4 == 0), 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 0, 0);

        // reset mid-burst with burst_remaining at 5, and a press alongside
        cur_div = 1; cur_blen = 8;
        cyc(0, 0, 0, 1, 0, 0, 2, 8);
        for (int j = 1; j <= 6; j++)
            cyc(0, 0, 0, 0, 0, (j % 2 == 0), 2, BW'(8 - j / 2));
        cyc(1, 0, 0, 1, 0, 0, 0, 0);
        for (int j = 0; j < 3; j++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0);

        // 16 steps on a 4-bit counter wrap it back to 0
        for (int p = 0; p < 16; p++) begin
            cyc(0, 1, 0, 0, 0, 1, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0, 0);
        end

        repeat (2) @(posedge sysclk);
        #2;
        chk("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
